// File: rtl/y_to_strip_id_pkg.sv
// y_to_strip_id_pkg: shared strip geometry, FSM states and the strip base formula.
package y_to_strip_id_pkg;
  localparam int Y_W = 8;
  localparam int ID_W = 4;
  localparam int NUM_STRIPS = 13;
  localparam logic [Y_W:0] Y_MAX = 9'd128;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  // Bases run 0..128; id 14 is the virtual strip that closes strip 13.
  function automatic logic [Y_W:0] strip_base(input logic [ID_W-1:0] id);
    logic [Y_W:0] i;
    i = {{(Y_W+1-ID_W){1'b0}}, id};
    return id == '0 ? '0 :
           id >= 4'd12 ? (i << 4) - 9'd96 :
           id[0] ? (i - 9'd1) << 3 :
           (i << 3) - (9'd9 - (i >> 1));
  endfunction
endpackage

// File: rtl/y_to_strip_id_lut.sv
// strip_base_lut: combinational strip id (1..14) to 9-bit y base.
module strip_base_lut
  import y_to_strip_id_pkg::*;
(
  input  logic [ID_W-1:0] id,
  output logic [Y_W:0]    base
);
  assign base = strip_base(id);
endmodule

// File: rtl/y_to_strip_id.sv
// y_to_strip_id: iterative y-row to strip id/offset/height search behind valid/ready.
module y_to_strip_id
  import y_to_strip_id_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [Y_W-1:0]  y_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [ID_W-1:0] strip_id_o,
  output logic [4:0]      offset_o,
  output logic [4:0]      height_o,
  output logic            err_o
);
  state_t state, state_nx;
  logic rdy_q, acc, big, hit;
  logic [Y_W-1:0] y_q;
  logic [ID_W-1:0] id_q, id_nx;
  logic [Y_W:0] base_lo, base_hi;
  assign id_nx = id_q + 4'd1;
  strip_base_lut u_lo (.id(id_q),  .base(base_lo));
  strip_base_lut u_hi (.id(id_nx), .base(base_hi));
  assign acc = state == IDLE && in_valid_i && rdy_q;
  assign big = {1'b0, y_i} >= Y_MAX;
  assign hit = {1'b0, y_q} < base_hi;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE   ? (acc ? (big ? DONE : SEARCH) : IDLE) :
               state == SEARCH ? (hit ? DONE : SEARCH) :
               (out_ready_i ? IDLE : DONE);
  always_comb begin
    in_ready_o = rdy_q;
    out_valid_o = state == DONE;
  end
  // Ready is registered so it stays low through reset and rises one clock after release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdy_q <= 1'b0;
      y_q <= '0;
      id_q <= '0;
      strip_id_o <= '0;
      offset_o <= '0;
      height_o <= '0;
      err_o <= 1'b0;
    end else begin
      rdy_q <= state_nx == IDLE;
      if (acc) begin
        y_q <= y_i;
        id_q <= 4'd1;
        strip_id_o <= '0;
        offset_o <= '0;
        height_o <= '0;
        err_o <= big;
      end else if (state == SEARCH) begin
        if (hit) begin
          strip_id_o <= id_q;
          offset_o <= 5'({1'b0, y_q} - base_lo);
          height_o <= 5'(base_hi - base_lo);
        end else id_q <= id_nx;
      end
    end
  end
endmodule

// File: tb/tb_y_to_strip_id.sv
// tb_y_to_strip_id: directed plus random y requests checked against a strip table model.
module tb_y_to_strip_id;
  logic clk_i = 0, rst_n_i = 0, in_valid_i = 0, out_ready_i = 0;
  logic [7:0] y_i = 0;
  logic in_ready_o, out_valid_o, err_o;
  logic [3:0] strip_id_o;
  logic [4:0] offset_o, height_o;
  int n_vec = 0, n_bad = 0;
  int base_tbl[14] = '{0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112, 128};

  always #5 clk_i = ~clk_i;

  y_to_strip_id dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .y_i(y_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .strip_id_o(strip_id_o), .offset_o(offset_o), .height_o(height_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int id, input int off, input int ht, input int er);
    chk({tag, ".valid"}, out_valid_o, 1);
    chk({tag, ".id"}, strip_id_o, id);
    chk({tag, ".offset"}, offset_o, off);
    chk({tag, ".height"}, height_o, ht);
    chk({tag, ".err"}, err_o, er);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".in_ready"}, in_ready_o, 0);
    chk({tag, ".out_valid"}, out_valid_o, 0);
    chk({tag, ".id"}, strip_id_o, 0);
    chk({tag, ".offset"}, offset_o, 0);
    chk({tag, ".height"}, height_o, 0);
    chk({tag, ".err"}, err_o, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_o && n < 50) begin @(negedge clk_i); n++; end
    chk("ready_wait", in_ready_o, 1);
  endtask

  // Model: first strip whose upper bound exceeds y; latency counted in clock edges after accept.
  task automatic req(input int y, input int hold);
    int id = 0, off = 0, ht = 0, er, n;
    er = y >= 128;
    if (!er) begin
      for (int k = 1; k <= 13; k++) if (id == 0 && y < base_tbl[k]) id = k;
      off = y - base_tbl[id-1];
      ht = base_tbl[id] - base_tbl[id-1];
      chk("recompose", base_tbl[id-1] + off, y);
    end
    wait_ready();
    in_valid_i = 1; y_i = y[7:0];
    @(posedge clk_i); @(negedge clk_i);
    in_valid_i = 0; y_i = 8'($urandom);
    n = 0;
    while (!out_valid_o && n < 20) begin
      chk("search_in_ready", in_ready_o, 0);
      @(negedge clk_i); n++;
    end
    chk($sformatf("latency y=%0d", y), n, er ? 0 : id);
    chk_out($sformatf("res y=%0d", y), id, off, ht, er);
    repeat (hold) begin
      in_valid_i = 1'($urandom); y_i = 8'($urandom);
      @(negedge clk_i);
      chk_out($sformatf("hold y=%0d", y), id, off, ht, er);
      chk("hold_in_ready", in_ready_o, 0);
    end
    in_valid_i = 0;
    out_ready_i = 1;
    @(posedge clk_i); @(negedge clk_i);
    out_ready_i = 0;
    chk("drain_valid", out_valid_o, 0);
    chk("drain_in_ready", in_ready_o, 1);
  endtask

  initial begin
    #1 chk_zero("reset");
    repeat (2) @(negedge clk_i);
    rst_n_i = 1;
    chk("post_reset_ready_low", in_ready_o, 0);
    @(negedge clk_i);
    chk("post_reset_ready_high", in_ready_o, 1);
    req(0, 0);
    req(24, 0);
    req(25, 1);
    req(127, 0);
    req(200, 0);
    req(128, 0);
    req(80, 5);
    for (int y = 0; y < 128; y++) req(y, int'($urandom_range(0, 2)));
    for (int i = 0; i < 30; i++) req(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    wait_ready();
    in_valid_i = 1; y_i = 8'd127;
    @(posedge clk_i); @(negedge clk_i);
    in_valid_i = 0;
    repeat (4) @(negedge clk_i);
    chk("mid_search_busy", out_valid_o, 0);
    rst_n_i = 0;
    #1 chk_zero("mid_reset");
    @(negedge clk_i);
    rst_n_i = 1;
    chk("rerelease_ready_low", in_ready_o, 0);
    @(negedge clk_i);
    chk("rerelease_ready_high", in_ready_o, 1);
    repeat (16) begin
      @(negedge clk_i);
      chk("no_spurious_valid", out_valid_o, 0);
    end
    req(127, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
